// File: rtl/bcd_pkg.sv
// Shared BCD types, constants and the nibble saturation helper for the
// four-digit counter.
package bcd_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX    = 4'd9;
    localparam int   NUM_DIGITS = 4;

    // Out-of-range load nibbles are clamped to 9 so a digit never leaves 0..9
    function automatic bcd_t bcd_sat(input logic [3:0] v);
        return (v > BCD_MAX) ? BCD_MAX : v;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade of the counter: up/down BCD digit with load and a ripple
// carry/borrow chain (count_in from the lower digit, count_out to the next).
module bcd_digit
    import bcd_pkg::*;
(
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_load,
    input  bcd_t i_load_val,
    input  logic i_count_in,
    input  logic i_up,
    output bcd_t o_digit,
    output logic o_count_out
);

    bcd_t r_digit;

    // Propagate to the next digit only when this one is about to roll over
    assign o_count_out = i_count_in && (i_up ? (r_digit == BCD_MAX) : (r_digit == 4'd0));
    assign o_digit     = r_digit;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_digit <= 4'd0;
        end else if (i_load) begin
            r_digit <= bcd_sat(i_load_val);
        end else if (i_count_in) begin
            if (i_up) begin
                r_digit <= (r_digit == BCD_MAX) ? 4'd0 : r_digit + 4'd1;
            end else begin
                r_digit <= (r_digit == 4'd0) ? BCD_MAX : r_digit - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_counter4.sv
// Four-digit BCD up/down counter with prescaler, load, wrap pulse and lamp test.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 always shown).
module bcd_counter4
    import bcd_pkg::*;
#(
    parameter int DIV = 50_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        up,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        test_in,
    output logic [15:0] digits,
    output logic [3:0]  blank,
    output logic        test_out,
    output logic        wrap
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    logic [PW-1:0]         r_presc;
    logic                  r_wrap;
    logic                  r_test;
    logic                  w_tick;
    logic [NUM_DIGITS:0]   w_carry;
    bcd_t                  w_digit [NUM_DIGITS];

    // A load in the same cycle swallows the tick so the loaded value is exact
    assign w_tick     = en && (r_presc == PRESC_LAST) && !load;
    assign w_carry[0] = w_tick;

    always_ff @(posedge clk) begin
        if (reset || load) begin
            r_presc <= '0;
        end else if (en) begin
            r_presc <= (r_presc == PRESC_LAST) ? '0 : r_presc + PW'(1);
        end
    end

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .i_clk       (clk),
            .i_reset     (reset),
            .i_load      (load),
            .i_load_val  (load_val[4*i +: 4]),
            .i_count_in  (w_carry[i]),
            .i_up        (up),
            .o_digit     (w_digit[i]),
            .o_count_out (w_carry[i+1])
        );
        assign digits[4*i +: 4] = w_digit[i];
    end

    // Carry out of the top digit means 9999->0000 or 0000->9999
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrap <= 1'b0;
            r_test <= 1'b0;
        end else begin
            r_wrap <= w_carry[NUM_DIGITS];
            r_test <= test_in;
        end
    end

    assign wrap     = r_wrap;
    assign test_out = r_test;

    always_comb begin
        blank = 4'b0000;
`ifdef LEADING_ZERO_BLANK_EN
        blank[3] = (w_digit[3] == 4'd0);
        blank[2] = blank[3] && (w_digit[2] == 4'd0);
        blank[1] = blank[2] && (w_digit[1] == 4'd0);
`endif
    end

endmodule
